i2c_rx_frame: RTL and testbench

//   Parametrised I2C receive engine; successor to the 1-bit/1-byte reader, for master and slave.

---
 rtl/i2c_rx_frame.sv | 143 ++++++++++++++
 tb/tb_i2c_rx_frame.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_rx_frame.sv
// I2C receive engine: synchronises and glitch-filters SCL/SDA, deserialises a 1-bit or
// DATA_W-bit frame, and reports start/stop conditions and misplaced ones as bus errors.
module i2c_rx_frame #(
   parameter int DATA_W    = 8,
   parameter int FILT_LEN  = 3,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scl_i,
   input  logic              sda_i,
   input  logic              rd_en,
   input  logic              is_frame,
   output logic [DATA_W-1:0] data_o,
   output logic              bit_o,
   output logic              data_valid,
   output logic              rd_finish,
   output logic              get_start,
   output logic              get_stop,
   output logic              bus_err,
   output logic [4:0]        bit_cnt_o,
   output logic [1:0]        state_o
);
   // Handshake: the controller raises rd_en after an SCL falling edge and holds it; the engine
   // answers with rd_finish (or bus_err) as a level until rd_en drops, which returns it to IDLE.

   localparam int FW = $clog2(FILT_LEN + 1);
   localparam int CW = 6;

   typedef enum logic [1:0] {IDLE, RECV, DONE, ERR} state_t;

   state_t            state;
   logic [1:0]        sync1, sync2, filt, prev;   // bit 0: SCL, bit 1: SDA
   logic [FW-1:0]     fcnt [2];
   logic              frame_mode;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shift_nx;
   logic [CW-1:0]     cnt_nx;
   logic              scl_f, sda_f;
   logic              scl_fall, sda_start, sda_stop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
         filt  <= '1;
         prev  <= '1;
         for (int i = 0; i < 2; i++) fcnt[i] <= '0;
      end else begin
         sync1 <= {sda_i, scl_i};
         sync2 <= sync1;
         prev  <= filt;
         // A line change is accepted only after FILT_LEN consecutive differing samples.
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
               filt[i] <= sync2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   assign scl_f     = filt[0];
   assign sda_f     = filt[1];
   assign scl_fall  = rd_en & prev[0] & ~filt[0];
   assign sda_start = rd_en & scl_f & prev[1] & ~filt[1];
   assign sda_stop  = rd_en & scl_f & ~prev[1] & filt[1];

   always_comb begin
      shift_nx = shreg;
      if (MSB_FIRST != 0) shift_nx = {shreg[DATA_W-2:0], bit_o};
      else                shift_nx = {bit_o, shreg[DATA_W-1:1]};
      cnt_nx = cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         frame_mode <= 1'b0;
         cnt        <= '0;
         shreg      <= '0;
         data_o     <= '0;
         bit_o      <= 1'b0;
         data_valid <= 1'b0;
         rd_finish  <= 1'b0;
         get_start  <= 1'b0;
         get_stop   <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         get_start  <= sda_start;
         get_stop   <= sda_stop;
         if (!rd_en) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_finish <= 1'b0;
            bus_err   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state      <= RECV;
                  frame_mode <= is_frame;
                  cnt        <= '0;
                  shreg      <= '0;
               end
               RECV: begin
                  if (scl_f) bit_o <= sda_f;
                  if (scl_fall) begin
                     shreg <= shift_nx;
                     cnt   <= cnt_nx;
                     if (cnt_nx == (frame_mode ? CW'(DATA_W) : CW'(1))) begin
                        state      <= DONE;
                        data_o     <= frame_mode ? shift_nx : {{(DATA_W-1){1'b0}}, bit_o};
                        data_valid <= 1'b1;
                        rd_finish  <= 1'b1;
                     end
                  end else if (sda_start || sda_stop) begin
                     // Only a frame that has not yet begun may be (re)started or stopped.
                     if (frame_mode && cnt == '0) begin
                        shreg <= '0;
                     end else begin
                        bus_err <= 1'b1;
                        state   <= ERR;
                     end
                  end
               end
               DONE:    state <= DONE;
               ERR:     state <= ERR;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bit_cnt_o = cnt[4:0];
   assign state_o   = state;

endmodule

// File: tb/tb_i2c_rx_frame.sv
// Directed bench for i2c_rx_frame: an MSB-first and an LSB-first instance share one bus and
// are checked against a vector table plus hand-written start/stop, glitch, abort and reset cases.
module tb_i2c_rx_frame;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1, sda = 1'b1, rd_en = 1'b0, is_frame = 1'b0;
   logic [7:0] data_m, data_l;
   logic       bit_m, bit_l, dv_m, dv_l, fin_m, fin_l;
   logic       gs_m, gs_l, gp_m, gp_l, err_m, err_l;
   logic [4:0] cnt_m, cnt_l;
   logic [1:0] st_m, st_l;

   int checks = 0;
   int errors = 0;
   int dv_cnt_m = 0, dv_cnt_l = 0, gs_cnt = 0, gp_cnt = 0;

   typedef struct {
      logic       frm;
      logic [7:0] seq;
      int         n;
      logic [7:0] exp_m;
      logic [7:0] exp_l;
      logic       exp_bit;
   } vec_t;
   vec_t vecs [5];

   always #5 clk = ~clk;

   i2c_rx_frame #(.DATA_W(8), .FILT_LEN(3), .MSB_FIRST(1)) dut_m (
      .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda), .rd_en(rd_en), .is_frame(is_frame),
      .data_o(data_m), .bit_o(bit_m), .data_valid(dv_m), .rd_finish(fin_m), .get_start(gs_m),
      .get_stop(gp_m), .bus_err(err_m), .bit_cnt_o(cnt_m), .state_o(st_m));

   i2c_rx_frame #(.DATA_W(8), .FILT_LEN(3), .MSB_FIRST(0)) dut_l (
      .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda), .rd_en(rd_en), .is_frame(is_frame),
      .data_o(data_l), .bit_o(bit_l), .data_valid(dv_l), .rd_finish(fin_l), .get_start(gs_l),
      .get_stop(gp_l), .bus_err(err_l), .bit_cnt_o(cnt_l), .state_o(st_l));

   always @(posedge clk) begin
      if (dv_m) dv_cnt_m++;
      if (dv_l) dv_cnt_l++;
      if (gs_m) gs_cnt++;
      if (gp_m) gp_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      sda = b;
      wait_clk(6);
      scl = 1'b1;
      wait_clk(8);
      scl = 1'b0;
      wait_clk(6);
   endtask

   initial begin
      int b_m, b_l, b_s, b_p;
      vecs[0] = '{1'b1, 8'hA5, 8, 8'hA5, 8'hA5, 1'b1};
      vecs[1] = '{1'b1, 8'h80, 8, 8'h80, 8'h01, 1'b0};
      vecs[2] = '{1'b1, 8'hC4, 8, 8'hC4, 8'h23, 1'b0};
      vecs[3] = '{1'b0, 8'h00, 1, 8'h00, 8'h00, 1'b0};
      vecs[4] = '{1'b0, 8'h80, 1, 8'h01, 8'h01, 1'b1};

      wait_clk(3);
      chk("reset data_m", 32'(data_m), 0);
      chk("reset data_l", 32'(data_l), 0);
      chk("reset flags", {dv_m, fin_m, gs_m, gp_m, err_m, bit_m}, 0);
      chk("reset cnt", 32'(cnt_m), 0);
      chk("reset state", 32'(st_m), 0);
      rst_n = 1'b1;
      scl = 1'b0;
      wait_clk(10);

      for (int v = 0; v < 5; v++) begin
         rd_en = 1'b1;
         is_frame = vecs[v].frm;
         wait_clk(2);
         b_m = dv_cnt_m;
         b_l = dv_cnt_l;
         for (int i = 0; i < vecs[v].n; i++) send_bit(vecs[v].seq[7-i]);
         wait_clk(4);
         chk($sformatf("v%0d data_m", v), 32'(data_m), 32'(vecs[v].exp_m));
         chk($sformatf("v%0d data_l", v), 32'(data_l), 32'(vecs[v].exp_l));
         chk($sformatf("v%0d bit_o", v), 32'(bit_m), 32'(vecs[v].exp_bit));
         chk($sformatf("v%0d bit_cnt", v), 32'(cnt_m), 32'(vecs[v].n));
         chk($sformatf("v%0d rd_finish", v), {fin_m, fin_l}, 2'b11);
         chk($sformatf("v%0d dv pulses", v), 32'((dv_cnt_m - b_m) + 10 * (dv_cnt_l - b_l)), 11);
         send_bit(~vecs[v].exp_bit);
         wait_clk(4);
         chk($sformatf("v%0d done hold data", v), 32'(data_m), 32'(vecs[v].exp_m));
         chk($sformatf("v%0d done hold cnt/bit", v), {cnt_m, bit_m}, {5'(vecs[v].n), vecs[v].exp_bit});
         chk($sformatf("v%0d done no dv", v), 32'(dv_cnt_m - b_m), 1);
         chk($sformatf("v%0d no err", v), 32'(err_m), 0);
         rd_en = 1'b0;
         wait_clk(2);
         chk($sformatf("v%0d release", v), {fin_m, cnt_m}, 0);
      end

      // Start before any bit in frame mode: pulse only
      rd_en = 1'b1;
      is_frame = 1'b1;
      b_s = gs_cnt;
      sda = 1'b1;
      wait_clk(6);
      scl = 1'b1;
      wait_clk(8);
      sda = 1'b0;
      wait_clk(8);
      chk("start pulse", 32'(gs_cnt - b_s), 1);
      chk("start no err", {err_m, err_l}, 0);
      chk("start cnt", 32'(cnt_m), 0);
      rd_en = 1'b0;
      wait_clk(2);
      scl = 1'b0;
      wait_clk(6);

      // Stop after 3 bits: error held until rd_en drops
      rd_en = 1'b1;
      wait_clk(2);
      b_m = dv_cnt_m;
      b_s = gs_cnt;
      b_p = gp_cnt;
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      chk("pre-stop cnt", 32'(cnt_m), 3);
      sda = 1'b0;
      wait_clk(6);
      scl = 1'b1;
      wait_clk(8);
      sda = 1'b1;
      wait_clk(8);
      chk("stop pulse", 32'(gp_cnt - b_p), 1);
      chk("stop no start", 32'(gs_cnt - b_s), 0);
      chk("stop bus_err", {err_m, err_l}, 2'b11);
      wait_clk(10);
      chk("bus_err held", 32'(err_m), 1);
      chk("err no dv", 32'(dv_cnt_m - b_m), 0);
      rd_en = 1'b0;
      wait_clk(2);
      chk("bus_err cleared", 32'(err_m), 0);
      scl = 1'b0;
      wait_clk(6);

      // SCL glitches while high: 2 cycles filtered out, 3 cycles accepted
      rd_en = 1'b1;
      wait_clk(2);
      sda = 1'b1;
      wait_clk(6);
      scl = 1'b1;
      wait_clk(8);
      scl = 1'b0;
      wait_clk(2);
      scl = 1'b1;
      wait_clk(10);
      chk("glitch2 cnt", 32'(cnt_m), 0);
      scl = 1'b0;
      wait_clk(3);
      scl = 1'b1;
      wait_clk(10);
      chk("glitch3 cnt", 32'(cnt_m), 1);
      rd_en = 1'b0;
      wait_clk(2);
      scl = 1'b0;
      wait_clk(6);

      // Abort after 5 bits, then a clean 0x3C frame
      rd_en = 1'b1;
      wait_clk(2);
      b_m = dv_cnt_m;
      b_l = dv_cnt_l;
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      rd_en = 1'b0;
      wait_clk(2);
      chk("abort cnt", 32'(cnt_m), 0);
      chk("abort data kept", 32'(data_m), 32'h01);
      rd_en = 1'b1;
      wait_clk(2);
      for (int i = 0; i < 8; i++) send_bit(i inside {2, 3, 4, 5});
      wait_clk(4);
      chk("after abort data_m", 32'(data_m), 32'h3C);
      chk("after abort data_l", 32'(data_l), 32'h3C);
      chk("after abort dv", 32'((dv_cnt_m - b_m) + 10 * (dv_cnt_l - b_l)), 11);
      rd_en = 1'b0;
      wait_clk(2);

      // Asynchronous reset in the middle of a frame
      rd_en = 1'b1;
      wait_clk(2);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset cnt", 32'(cnt_m), 0);
      chk("async reset data", {data_m, data_l}, 0);
      chk("async reset state", 32'(st_m), 0);
      rd_en = 1'b0;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
